processor_dp: RTL and testbench

PROCESSOR_DP -- requirements
Module: processor_dp

---
 rtl/processor_dp.sv | 101 ++++++++++
 tb/tb_processor_dp.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/processor_dp.sv
// rtl/processor_dp.sv - accumulator datapath: 32x8 RAM, IR, PC, A and status flags
// Optional sticky signed-overflow flag ovf_o is built only when DP_OVF_EN is defined.
module processor_dp (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ir_load_i,
  input  logic       pc_load_i,
  input  logic       jmp_mux_i,
  input  logic       mem_inst_i,
  input  logic       mem_wr_i,
  input  logic       a_load_i,
  input  logic       sub_i,
  input  logic [1:0] a_sel_i,
  input  logic       halt_i,
  input  logic [7:0] input_i,
  input  logic       ld_en_i,
  input  logic [4:0] ld_addr_i,
  input  logic [7:0] ld_data_i,
  output logic [2:0] ir_o,
  output logic       a_eq0_o,
  output logic       a_pos_o,
  output logic [7:0] output_o,
  output logic [4:0] pc_o
`ifdef DP_OVF_EN
  ,
  output logic       ovf_o
`endif
);

  logic [7:0] mem_q [32];
  logic [7:0] ir_q, ir_d;
  logic [4:0] pc_q, pc_d;
  logic [7:0] a_q, a_d;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;
  logic [7:0] alu_res;
  logic       upd;

  assign upd      = ~halt_i;
  assign mem_addr = mem_inst_i ? ir_q[4:0] : pc_q;
  assign mem_data = mem_q[mem_addr];
  assign alu_res  = sub_i ? (a_q - mem_data) : (a_q + mem_data);

  always_comb begin
    ir_d = ir_q;
    pc_d = pc_q;
    a_d  = a_q;
    if (ir_load_i && upd) ir_d = mem_data;
    if (pc_load_i && upd) pc_d = jmp_mux_i ? ir_q[4:0] : pc_q + 5'd1;
    if (a_load_i && upd) begin
      case (a_sel_i)
        2'b00:   a_d = alu_res;
        2'b01:   a_d = input_i;
        2'b10:   a_d = mem_data;
        default: a_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ir_q <= 8'h00;
      pc_q <= 5'd0;
      a_q  <= 8'h00;
    end else begin
      ir_q <= ir_d;
      pc_q <= pc_d;
      a_q  <= a_d;
    end
  end

  // RAM survives reset, but a load landing while reset is held is dropped
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (ld_en_i) mem_q[ld_addr_i] <= ld_data_i;
      else if (mem_wr_i && upd) mem_q[mem_addr] <= a_q;
    end
  end

`ifdef DP_OVF_EN
  logic ovf_q, ovf_d, alu_ovf;

  assign alu_ovf = sub_i ? ((a_q[7] != mem_data[7]) && (alu_res[7] != a_q[7]))
                         : ((a_q[7] == mem_data[7]) && (alu_res[7] != a_q[7]));
  assign ovf_d   = ovf_q | (a_load_i && upd && (a_sel_i == 2'b00) && alu_ovf);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`endif

  assign ir_o     = ir_q[7:5];
  assign a_eq0_o  = (a_q == 8'h00);
  assign a_pos_o  = ~a_q[7] & ~a_eq0_o;
  assign output_o = a_q;
  assign pc_o     = pc_q;

endmodule

// File: tb/tb_processor_dp.sv
// tb/tb_processor_dp.sv - directed self-checking bench for processor_dp
// Overflow checks are compiled in only when DP_OVF_EN is defined.
module tb_processor_dp;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       ir_load_i, pc_load_i, jmp_mux_i, mem_inst_i, mem_wr_i;
  logic       a_load_i, sub_i, halt_i, ld_en_i;
  logic [1:0] a_sel_i;
  logic [7:0] input_i, ld_data_i;
  logic [4:0] ld_addr_i;
  logic [2:0] ir_o;
  logic       a_eq0_o, a_pos_o;
  logic [7:0] output_o;
  logic [4:0] pc_o;
`ifdef DP_OVF_EN
  logic       ovf_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  processor_dp dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ir_load_i  (ir_load_i),
    .pc_load_i  (pc_load_i),
    .jmp_mux_i  (jmp_mux_i),
    .mem_inst_i (mem_inst_i),
    .mem_wr_i   (mem_wr_i),
    .a_load_i   (a_load_i),
    .sub_i      (sub_i),
    .a_sel_i    (a_sel_i),
    .halt_i     (halt_i),
    .input_i    (input_i),
    .ld_en_i    (ld_en_i),
    .ld_addr_i  (ld_addr_i),
    .ld_data_i  (ld_data_i),
    .ir_o       (ir_o),
    .a_eq0_o    (a_eq0_o),
    .a_pos_o    (a_pos_o),
    .output_o   (output_o),
    .pc_o       (pc_o)
`ifdef DP_OVF_EN
    ,
    .ovf_o      (ovf_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    ir_load_i = 0; pc_load_i = 0; jmp_mux_i = 0; mem_inst_i = 0; mem_wr_i = 0;
    a_load_i = 0; sub_i = 0; a_sel_i = 2'b00; halt_i = 0; ld_en_i = 0;
  endtask

  task automatic load_ram(input logic [4:0] addr, input logic [7:0] data);
    ld_en_i = 1; ld_addr_i = addr; ld_data_i = data;
    step();
    ld_en_i = 0;
  endtask

  task automatic load_a(input logic [1:0] sel, input logic minst, input logic sb);
    a_load_i = 1; a_sel_i = sel; mem_inst_i = minst; sub_i = sb;
    step();
    idle();
  endtask

  task automatic load_in(input logic [7:0] v);
    input_i = v;
    load_a(2'b01, 1'b0, 1'b0);
  endtask

  initial begin
    rst_i = 1; input_i = 8'h00; ld_addr_i = 5'd0; ld_data_i = 8'h00;
    idle();
    step(); step();
    check_eq("rst_pc", 32'(pc_o), 32'h0);
    check_eq("rst_ir", 32'(ir_o), 32'h0);
    check_eq("rst_out", 32'(output_o), 32'h0);
    check_eq("rst_aeq0", 32'(a_eq0_o), 32'h1);
    check_eq("rst_apos", 32'(a_pos_o), 32'h0);
`ifdef DP_OVF_EN
    check_eq("rst_ovf", 32'(ovf_o), 32'h0);
`endif
    rst_i = 0;

    load_ram(5'd0, 8'h1F);
    load_ram(5'd1, 8'hA7);
    load_ram(5'd7, 8'h3F);
    load_ram(5'd31, 8'h03);

    ir_load_i = 1; pc_load_i = 1; step(); idle();
    check_eq("fetch_ir", 32'(ir_o), 32'h0);
    check_eq("fetch_pc", 32'(pc_o), 32'h1);

    load_in(8'h05);
    check_eq("in_05", 32'(output_o), 32'h05);
    load_a(2'b00, 1'b1, 1'b1);
    check_eq("sub_a", 32'(output_o), 32'h02);
    check_eq("sub_aeq0", 32'(a_eq0_o), 32'h0);
    check_eq("sub_apos", 32'(a_pos_o), 32'h1);

    ir_load_i = 1; pc_load_i = 1; step(); idle();
    check_eq("fetch2_ir", 32'(ir_o), 32'h5);
    check_eq("fetch2_pc", 32'(pc_o), 32'h2);
    pc_load_i = 1; jmp_mux_i = 1; step(); idle();
    check_eq("jmp_pc7", 32'(pc_o), 32'h7);

    ir_load_i = 1; step(); idle();
    check_eq("ir_only_ir", 32'(ir_o), 32'h1);
    check_eq("ir_only_pc", 32'(pc_o), 32'h7);
    pc_load_i = 1; jmp_mux_i = 1; step(); idle();
    check_eq("jmp_pc31", 32'(pc_o), 32'd31);
    pc_load_i = 1; step(); idle();
    check_eq("pc_wrap", 32'(pc_o), 32'h0);

    load_a(2'b00, 1'b1, 1'b1);
    check_eq("sub_neg", 32'(output_o), 32'hFF);
    check_eq("neg_apos", 32'(a_pos_o), 32'h0);
    check_eq("neg_aeq0", 32'(a_eq0_o), 32'h0);
    load_a(2'b00, 1'b1, 1'b0);
    check_eq("add_wrap", 32'(output_o), 32'h02);
    load_a(2'b11, 1'b0, 1'b0);
    check_eq("zero_a", 32'(output_o), 32'h00);
    check_eq("zero_aeq0", 32'(a_eq0_o), 32'h1);
    load_a(2'b10, 1'b1, 1'b0);
    check_eq("memdata_a", 32'(output_o), 32'h03);

    load_in(8'h80);
    check_eq("in_80", 32'(output_o), 32'h80);
    check_eq("in80_apos", 32'(a_pos_o), 32'h0);
    check_eq("in80_aeq0", 32'(a_eq0_o), 32'h0);
    halt_i = 1; a_load_i = 1; a_sel_i = 2'b11; pc_load_i = 1; ir_load_i = 1;
    step(); idle();
    check_eq("halt_a", 32'(output_o), 32'h80);
    check_eq("halt_pc", 32'(pc_o), 32'h0);
    check_eq("halt_ir", 32'(ir_o), 32'h1);
    halt_i = 1; mem_wr_i = 1; mem_inst_i = 1; step(); idle();
    load_a(2'b10, 1'b1, 1'b0);
    check_eq("halt_memwr", 32'(output_o), 32'h03);

    load_ram(5'd0, 8'h04);
    ir_load_i = 1; step(); idle();
    load_in(8'hAA);
    ld_en_i = 1; ld_addr_i = 5'd4; ld_data_i = 8'h55; mem_wr_i = 1; mem_inst_i = 1;
    step(); idle();
    load_a(2'b10, 1'b1, 1'b0);
    check_eq("ld_prio", 32'(output_o), 32'h55);
    load_in(8'hAA);
    mem_wr_i = 1; mem_inst_i = 1; step(); idle();
    load_a(2'b11, 1'b0, 1'b0);
    load_a(2'b10, 1'b1, 1'b0);
    check_eq("memwr_a", 32'(output_o), 32'hAA);

    pc_load_i = 1; step(); step(); idle();
    check_eq("pc_adv", 32'(pc_o), 32'h2);
    rst_i = 1;
    #1;
    check_eq("arst_pc", 32'(pc_o), 32'h0);
    check_eq("arst_out", 32'(output_o), 32'h0);
    check_eq("arst_aeq0", 32'(a_eq0_o), 32'h1);
    check_eq("arst_ir", 32'(ir_o), 32'h0);
    ld_en_i = 1; ld_addr_i = 5'd0; ld_data_i = 8'h77; step();
    ld_en_i = 0; rst_i = 0;
    load_a(2'b10, 1'b0, 1'b0);
    check_eq("rst_ld_abort", 32'(output_o), 32'h04);

`ifdef DP_OVF_EN
    load_ram(5'd0, 8'h01);
    load_in(8'h7F);
    check_eq("ovf_pre", 32'(ovf_o), 32'h0);
    load_a(2'b00, 1'b1, 1'b0);
    check_eq("ovf_a", 32'(output_o), 32'h80);
    check_eq("ovf_set", 32'(ovf_o), 32'h1);
    load_in(8'h01);
    load_a(2'b00, 1'b1, 1'b0);
    check_eq("ovf_add2", 32'(output_o), 32'h02);
    check_eq("ovf_sticky", 32'(ovf_o), 32'h1);
    pc_load_i = 1; step(); idle();
    #2 rst_i = 1;
    #1;
    check_eq("ovf_rst", 32'(ovf_o), 32'h0);
    check_eq("ovf_rst_pc", 32'(pc_o), 32'h0);
    step();
    rst_i = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
